// File: rtl/jump_ctl.sv
// MIX jump-instruction controller: conditional jumps (op 39) and register-sign jumps (op 40..47).
// Optional macro JREG_PARITY_EN adds the even/odd register jumps (fields 6 and 7 of op 40..47).
//
// state  | meaning
// IDLE   | waiting for start, inputs latched on acceptance
// READ   | one-cycle register read strobe
// RWAIT  | register data returns, captured at end of cycle
// EVAL   | jump condition resolved, results registered
// COMMIT | done/taken/side-effect pulses visible for one cycle
module jump_ctl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [5:0]  field,
    input  logic [11:0] m,
    input  logic [11:0] pc_next,
    input  logic [1:0]  cmp,
    input  logic        ovf,
    output logic        rd_req,
    output logic [2:0]  rd_idx,
    input  logic [30:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        pc_load,
    output logic [11:0] pc_out,
    output logic        rj_we,
    output logic [11:0] rj_out,
    output logic        ovf_clr,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        RWAIT  = 3'd2,
        EVAL   = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [5:0]  field_q, field_d;
    logic [11:0] m_q, m_d;
    logic [11:0] pcn_q, pcn_d;
    logic [30:0] data_q, data_d;

    logic        rd_req_q, rd_req_d;
    logic [2:0]  rd_idx_q, rd_idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        taken_q, taken_d;
    logic        pc_load_q, pc_load_d;
    logic [11:0] pc_out_q, pc_out_d;
    logic        rj_we_q, rj_we_d;
    logic [11:0] rj_out_q, rj_out_d;
    logic        ovf_clr_q, ovf_clr_d;
    logic        err_q, err_d;

    logic        mag_zero, is_neg, is_pos;
    logic        legal, cond;

    // Sign-magnitude: -0 has zero magnitude and counts as neither negative nor positive.
    always_comb begin
        mag_zero = (data_q[29:0] == 30'd0);
        is_neg   = data_q[30] & ~mag_zero;
        is_pos   = ~data_q[30] & ~mag_zero;
        legal    = 1'b1;
        cond     = 1'b0;
        if (op_q == 6'd39) begin
            case (field_q)
                6'd0, 6'd1: cond = 1'b1;
                6'd2:       cond = ovf;
                6'd3:       cond = ~ovf;
                6'd4:       cond = (cmp == 2'd0);
                6'd5:       cond = (cmp == 2'd1);
                6'd6:       cond = (cmp == 2'd2);
                6'd7:       cond = (cmp != 2'd0);
                6'd8:       cond = (cmp != 2'd1);
                6'd9:       cond = (cmp != 2'd2);
                default:    legal = 1'b0;
            endcase
        end else begin
            case (field_q)
                6'd0:    cond = is_neg;
                6'd1:    cond = mag_zero;
                6'd2:    cond = is_pos;
                6'd3:    cond = ~is_neg;
                6'd4:    cond = ~mag_zero;
                6'd5:    cond = ~is_pos;
`ifdef JREG_PARITY_EN
                6'd6:    cond = ~data_q[0];
                6'd7:    cond = data_q[0];
`endif
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        field_d   = field_q;
        m_d       = m_q;
        pcn_d     = pcn_q;
        data_d    = data_q;
        done_d    = 1'b0;
        taken_d   = 1'b0;
        pc_load_d = 1'b0;
        pc_out_d  = 12'd0;
        rj_we_d   = 1'b0;
        rj_out_d  = 12'd0;
        ovf_clr_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    field_d = field;
                    m_d     = m;
                    pcn_d   = pc_next;
                    if (op == 6'd39) begin
                        state_d = EVAL;
                    end else if (op >= 6'd40 && op <= 6'd47) begin
                        state_d = READ;
                    end else begin
                        state_d = COMMIT;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            READ:  state_d = RWAIT;
            RWAIT: begin
                data_d  = rd_data;
                state_d = EVAL;
            end
            EVAL: begin
                state_d = COMMIT;
                done_d  = 1'b1;
                if (legal) begin
                    taken_d   = cond;
                    pc_load_d = cond;
                    pc_out_d  = cond ? m_q : 12'd0;
                    // JSJ jumps without saving the return address.
                    rj_we_d   = cond && !(op_q == 6'd39 && field_q == 6'd1);
                    rj_out_d  = rj_we_d ? pcn_q : 12'd0;
                    ovf_clr_d = (op_q == 6'd39) && (field_q == 6'd2 || field_q == 6'd3);
                end else begin
                    err_d = 1'b1;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d != IDLE);
        rd_req_d = (state_d == READ);
        // Opcodes 40..47 carry the register index in their low three bits.
        rd_idx_d = rd_req_d ? op_d[2:0] : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 6'd0;
            field_q   <= 6'd0;
            m_q       <= 12'd0;
            pcn_q     <= 12'd0;
            data_q    <= 31'd0;
            rd_req_q  <= 1'b0;
            rd_idx_q  <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            pc_load_q <= 1'b0;
            pc_out_q  <= 12'd0;
            rj_we_q   <= 1'b0;
            rj_out_q  <= 12'd0;
            ovf_clr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            field_q   <= field_d;
            m_q       <= m_d;
            pcn_q     <= pcn_d;
            data_q    <= data_d;
            rd_req_q  <= rd_req_d;
            rd_idx_q  <= rd_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            taken_q   <= taken_d;
            pc_load_q <= pc_load_d;
            pc_out_q  <= pc_out_d;
            rj_we_q   <= rj_we_d;
            rj_out_q  <= rj_out_d;
            ovf_clr_q <= ovf_clr_d;
            err_q     <= err_d;
        end
    end

    assign rd_req  = rd_req_q;
    assign rd_idx  = rd_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign taken   = taken_q;
    assign pc_load = pc_load_q;
    assign pc_out  = pc_out_q;
    assign rj_we   = rj_we_q;
    assign rj_out  = rj_out_q;
    assign ovf_clr = ovf_clr_q;
    assign err     = err_q;

endmodule

// File: tb/tb_jump_ctl.sv
// Randomized bench for jump_ctl against a behavioural jump model; also honours JREG_PARITY_EN.
module tb_jump_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  op;
    logic [5:0]  field;
    logic [11:0] m;
    logic [11:0] pc_next;
    logic [1:0]  cmp;
    logic        ovf;
    logic        rd_req;
    logic [2:0]  rd_idx;
    logic [30:0] rd_data;
    logic        busy, done, taken, pc_load;
    logic [11:0] pc_out;
    logic        rj_we;
    logic [11:0] rj_out;
    logic        ovf_clr, err;

    int          n_vec = 0;
    int          n_err = 0;
    logic        req_seen = 1'b0;
    logic [30:0] reg_val = 31'd0;

    always #5 clk = ~clk;

    jump_ctl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .field(field), .m(m),
        .pc_next(pc_next), .cmp(cmp), .ovf(ovf), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_data(rd_data), .busy(busy), .done(done), .taken(taken), .pc_load(pc_load),
        .pc_out(pc_out), .rj_we(rj_we), .rj_out(rj_out), .ovf_clr(ovf_clr), .err(err)
    );

    // Register file: data is valid only in the cycle after rd_req, garbage otherwise.
    always @(negedge clk) req_seen = rd_req;
    always @(posedge clk) begin
        #1;
        rd_data = req_seen ? reg_val : 31'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return 64'({rd_req, rd_idx, busy, done, taken, pc_load, pc_out,
                    rj_we, rj_out, ovf_clr, err});
    endfunction

    // Behavioural model: latency and result of one instruction.
    task automatic model(input int t_op, input int t_field, input int t_cmp, input bit t_ovf,
                         input logic [30:0] t_reg, output int lat, output bit reads,
                         output int idx, output bit tk, output bit er, output bit rjw,
                         output bit oc);
        longint mag, val;
        reads = 0; idx = 0; tk = 0; er = 0; rjw = 0; oc = 0;
        mag = longint'(t_reg[29:0]);
        val = t_reg[30] ? -mag : mag;
        if (t_op == 39) begin
            lat = 2;
            case (t_field)
                0, 1: tk = 1;
                2:    tk = t_ovf;
                3:    tk = !t_ovf;
                4:    tk = (t_cmp == 0);
                5:    tk = (t_cmp == 1);
                6:    tk = (t_cmp == 2);
                7:    tk = (t_cmp == 1 || t_cmp == 2);
                8:    tk = (t_cmp == 0 || t_cmp == 2);
                9:    tk = (t_cmp == 0 || t_cmp == 1);
                default: er = 1;
            endcase
            oc  = !er && (t_field == 2 || t_field == 3);
            rjw = tk && (t_field != 1);
        end else if (t_op >= 40 && t_op <= 47) begin
            lat   = 4;
            reads = 1;
            idx   = t_op - 40;
            case (t_field)
                0: tk = (val < 0);
                1: tk = (mag == 0);
                2: tk = (val > 0);
                3: tk = !(val < 0);
                4: tk = (mag != 0);
                5: tk = !(val > 0);
`ifdef JREG_PARITY_EN
                6: tk = (mag % 2 == 0);
                7: tk = (mag % 2 == 1);
`endif
                default: er = 1;
            endcase
            rjw = tk;
        end else begin
            lat = 1;
            er  = 1;
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following done.
    task automatic run_txn(input int t_op, input int t_field, input int t_m, input int t_pc,
                           input int t_cmp, input bit t_ovf, input logic [30:0] t_reg,
                           input bit hold);
        int lat, idx;
        bit reads, tk, er, rjw, oc;
        logic [7:0] exp_ctl;
        model(t_op, t_field, t_cmp, t_ovf, t_reg, lat, reads, idx, tk, er, rjw, oc);
        op      = 6'(t_op);
        field   = 6'(t_field);
        m       = 12'(t_m);
        pc_next = 12'(t_pc);
        cmp     = 2'(t_cmp);
        ovf     = t_ovf;
        reg_val = t_reg;
        start   = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            op      = 6'($urandom);
            field   = 6'($urandom);
            m       = 12'($urandom);
            pc_next = 12'($urandom);
        end else begin
            start = 1'b0;
        end
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            exp_ctl = {k <= lat, reads && k == 1, k == lat, tk && k == lat, tk && k == lat,
                       rjw && k == lat, oc && k == lat, er && k == lat};
            chk($sformatf("ctl op%0d f%0d cyc%0d", t_op, t_field, k),
                64'({busy, rd_req, done, taken, pc_load, rj_we, ovf_clr, err}), 64'(exp_ctl));
            if (reads && k == 1)
                chk($sformatf("rd_idx op%0d", t_op), 64'(rd_idx), 64'(idx));
            if (tk && k == lat)
                chk($sformatf("pc_out op%0d f%0d", t_op, t_field), 64'(pc_out), 64'(t_m[11:0]));
            if (rjw && k == lat)
                chk($sformatf("rj_out op%0d f%0d", t_op, t_field), 64'(rj_out), 64'(t_pc[11:0]));
            if (k == lat) start = 1'b0;
        end
    endtask

    task automatic abort_in_rwait();
        op = 6'd40; field = 6'd1; m = 12'd300; pc_next = 12'd301;
        reg_val = 31'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1 chk("abort_now", all_out(), 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold", all_out(), 64'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_after", all_out(), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r_op, r_field, r_mag;
        logic [30:0] r_reg;
        rst_n = 1'b0; start = 1'b0; op = 6'd0; field = 6'd0; m = 12'd0;
        pc_next = 12'd0; cmp = 2'd0; ovf = 1'b0;
        #1 chk("reset", all_out(), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle", all_out(), 64'd0);

        run_txn(39, 0, 1000, 501, 1, 0, 31'd0, 0);
        run_txn(39, 1, 200, 77, 0, 0, 31'd0, 0);
        run_txn(39, 2, 123, 45, 2, 0, 31'd0, 0);
        run_txn(39, 3, 124, 46, 2, 0, 31'd0, 0);
        run_txn(40, 1, 900, 17, 0, 0, 31'h4000_0000, 0);
        run_txn(40, 0, 901, 18, 0, 0, 31'h4000_0000, 0);
        run_txn(40, 2, 902, 19, 0, 0, 31'h4000_0000, 0);
        run_txn(47, 2, 555, 66, 1, 1, 31'd5, 0);
        run_txn(39, 10, 777, 88, 1, 1, 31'd0, 0);
        run_txn(45, 0, 10, 11, 0, 0, 31'h4000_0003, 0);
        run_txn(50, 0, 10, 11, 0, 0, 31'd0, 0);
        abort_in_rwait();
        run_txn(40, 1, 333, 334, 0, 0, 31'd0, 0);
        run_txn(41, 3, 444, 445, 1, 0, 31'h4000_0007, 1);
        run_txn(39, 1, 12, 13, 0, 0, 31'd0, 1);
        run_txn(41, 6, 1234, 99, 0, 0, 31'd4, 0);
        run_txn(42, 7, 1235, 98, 0, 0, 31'h4000_0009, 0);

        for (int i = 0; i < 400; i++) begin
            r_op    = ($urandom_range(0, 15) < 14) ? int'($urandom_range(37, 50))
                                                   : int'($urandom_range(0, 63));
            r_field = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, 11))
                                                   : int'($urandom_range(0, 63));
            r_mag   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 9));
            r_reg   = {1'($urandom), 30'(r_mag)};
            if ($urandom_range(0, 1) == 1) r_reg[29:4] = 26'($urandom);
            run_txn(r_op, r_field, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 2)), 1'($urandom), r_reg,
                    $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
